uart_cmd_ctrl: RTL and testbench

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_cmd_pkg.sv | 23 ++
 rtl/uart_cmd_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
// Shared definitions for the UART command controller: the frame-parser state
// enum and the protocol byte values (frame start, command codes, response
// bytes).
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_ADDR = 3'd2,
      ST_DATA = 3'd3,
      ST_REQ  = 3'd4,
      ST_RESP = 3'd5,
      ST_ERR  = 3'd6
   } state_t;

   localparam logic [7:0] SOF       = 8'h5A;
   localparam logic [7:0] CMD_READ  = 8'h01;
   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] RSP_ACK   = 8'hA5;
   localparam logic [7:0] RSP_ERR   = 8'hEE;

endpackage

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
// Parses command frames from a UART receive FIFO, performs one register
// access per frame and returns the response through the UART transmit FIFO.
//   Frame : 5A, CMD (01 read / 02 write), ADDR, [4 data bytes LSB-first, write only]
//   Reply : read -> 4 data bytes LSB-first, write -> A5, bad CMD -> EE
// Ports
//   CLK_I, RST_I             clock, synchronous active-high reset
//   RX_EMPTY_I, RE_O, DREC_I receive FIFO: empty flag, read strobe, byte
//   TX_READY_I, WE_O, DSEND_O transmit FIFO: space flag, write strobe, byte
//   REG_REQ_O .. REG_WDATA_O register request, type, address, write data
//   REG_ACK_I, REG_RDATA_I   register completion strobe and read data
// An idle gap of TIMEOUT_CYCLES between bytes inside a frame drops the frame.
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        RX_EMPTY_I,
   output logic        RE_O,
   input  logic [7:0]  DREC_I,
   input  logic        TX_READY_I,
   output logic        WE_O,
   output logic [7:0]  DSEND_O,
   output logic        REG_REQ_O,
   output logic        REG_WE_O,
   output logic [7:0]  REG_ADDR_O,
   output logic [31:0] REG_WDATA_O,
   input  logic        REG_ACK_I,
   input  logic [31:0] REG_RDATA_I
);

   localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        state_q,  state_d;
   logic          reg_we_q, reg_we_d;
   logic [7:0]    addr_q,   addr_d;
   logic [31:0]   wdata_q,  wdata_d;
   logic [1:0]    cnt_q,    cnt_d;
   logic [TW-1:0] timer_q,  timer_d;
   logic [31:0]   rsp_q,    rsp_d;
   logic [2:0]    left_q,   left_d;

   logic          re;
   logic          wr;
   logic [7:0]    dsend;
   logic          byte_avail;
   logic          tx_ok;
   logic          in_frame;

   // Strobes are held off during the reset cycle so no FIFO byte is popped
   // or pushed by a frame that the reset is about to abandon.
   assign byte_avail = !RST_I && !RX_EMPTY_I;
   assign tx_ok      = !RST_I && TX_READY_I;
   assign in_frame   = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);

   always_comb begin
      state_d  = state_q;
      reg_we_d = reg_we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      timer_d  = '0;
      rsp_d    = rsp_q;
      left_d   = left_q;
      re       = 1'b0;
      wr       = 1'b0;
      dsend    = 8'h00;

      // Gap timer: runs only while waiting for the next byte of a frame.
      if (in_frame && !byte_avail) begin
         if (timer_q == TMO_LAST) begin
            state_d = ST_IDLE;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (byte_avail) begin
               re = 1'b1;
               if (DREC_I == SOF) begin
                  state_d = ST_CMD;
               end
            end
         end
         ST_CMD: begin
            if (byte_avail) begin
               re = 1'b1;
               if ((DREC_I == CMD_READ) || (DREC_I == CMD_WRITE)) begin
                  reg_we_d = (DREC_I == CMD_WRITE);
                  state_d  = ST_ADDR;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_ADDR: begin
            if (byte_avail) begin
               re      = 1'b1;
               addr_d  = DREC_I;
               cnt_d   = 2'd0;
               state_d = reg_we_q ? ST_DATA : ST_REQ;
            end
         end
         ST_DATA: begin
            if (byte_avail) begin
               re                    = 1'b1;
               wdata_d[8*cnt_q +: 8] = DREC_I;
               cnt_d                 = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (REG_ACK_I) begin
               state_d = ST_RESP;
               if (reg_we_q) begin
                  rsp_d  = {24'h000000, RSP_ACK};
                  left_d = 3'd1;
               end else begin
                  rsp_d  = REG_RDATA_I;
                  left_d = 3'd4;
               end
            end
         end
         ST_RESP: begin
            if (tx_ok) begin
               wr     = 1'b1;
               dsend  = rsp_q[7:0];
               // Shifting leaves the response register at zero once drained.
               rsp_d  = {8'h00, rsp_q[31:8]};
               left_d = left_q - 3'd1;
               if (left_q == 3'd1) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_ERR: begin
            if (tx_ok) begin
               wr      = 1'b1;
               dsend   = RSP_ERR;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q  <= ST_IDLE;
         reg_we_q <= 1'b0;
         addr_q   <= 8'h00;
         wdata_q  <= 32'h0;
         cnt_q    <= 2'd0;
         timer_q  <= '0;
         rsp_q    <= 32'h0;
         left_q   <= 3'd0;
      end else begin
         state_q  <= state_d;
         reg_we_q <= reg_we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         timer_q  <= timer_d;
         rsp_q    <= rsp_d;
         left_q   <= left_d;
      end
   end

   assign RE_O        = re;
   assign WE_O        = wr;
   assign DSEND_O     = dsend;
   assign REG_REQ_O   = (state_q == ST_REQ);
   assign REG_WE_O    = reg_we_q;
   assign REG_ADDR_O  = addr_q;
   assign REG_WDATA_O = wdata_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl
// Bench for uart_cmd_ctrl. A frame-level model turns each byte stream into
// the expected register requests and transmitted bytes; one monitor (inside
// tick) compares every DUT strobe against those queues each cycle.
module tb_uart_cmd_ctrl;

   typedef struct packed {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
   } req_t;

   logic        clk = 1'b0;
   logic        RST_I = 1'b1;
   logic        RX_EMPTY_I = 1'b1;
   logic        RE_O;
   logic [7:0]  DREC_I = 8'h00;
   logic        TX_READY_I = 1'b1;
   logic        WE_O;
   logic [7:0]  DSEND_O;
   logic        REG_REQ_O;
   logic        REG_WE_O;
   logic [7:0]  REG_ADDR_O;
   logic [31:0] REG_WDATA_O;
   logic        REG_ACK_I = 1'b0;
   logic [31:0] REG_RDATA_I = 32'h0;

   always #5 clk = ~clk;

   uart_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
      .CLK_I(clk), .RST_I(RST_I),
      .RX_EMPTY_I(RX_EMPTY_I), .RE_O(RE_O), .DREC_I(DREC_I),
      .TX_READY_I(TX_READY_I), .WE_O(WE_O), .DSEND_O(DSEND_O),
      .REG_REQ_O(REG_REQ_O), .REG_WE_O(REG_WE_O), .REG_ADDR_O(REG_ADDR_O),
      .REG_WDATA_O(REG_WDATA_O), .REG_ACK_I(REG_ACK_I), .REG_RDATA_I(REG_RDATA_I)
   );

   logic [7:0]  rx_q[$];
   logic [7:0]  frm[$];
   logic [7:0]  exp_tx[$];
   req_t        exp_req[$];
   logic [31:0] periph[256];
   logic [31:0] mdl_mem[256];

   int   n_cmp = 0;
   int   n_bad = 0;
   bit   ack_en = 1'b1;
   int   ack_delay = 0;
   int   ack_cnt = 0;
   bit   req_active = 1'b0;
   bit   expect_drop = 1'b0;
   bit   stray_ack = 1'b0;
   req_t cur_req;
   int   pending_tx = 0;
   int   tx_mode = 0;
   int   cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string msg);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %s", name, msg);
   endtask

   task automatic refresh_rx();
      RX_EMPTY_I = (rx_q.size() == 0);
      DREC_I     = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
   endtask

   // One clock cycle: monitor at the falling edge, FIFO/ready updates just
   // after the rising edge.
   task automatic tick();
      logic re_s;
      req_t e;
      refresh_rx();
      @(negedge clk);
      re_s      = 1'b0;
      REG_ACK_I = 1'b0;
      if (!RST_I) begin
         re_s = RE_O;
         if (expect_drop) begin
            check("req_drop", {63'h0, REG_REQ_O}, 64'h0);
            expect_drop = 1'b0;
         end
         if (RE_O) begin
            check("re_nonempty", {63'h0, RX_EMPTY_I}, 64'h0);
            check("re_blocked", {63'h0, (pending_tx > 0) || REG_REQ_O}, 64'h0);
         end
         if (WE_O) begin
            check("we_ready", {63'h0, TX_READY_I}, 64'h1);
            if (exp_tx.size() == 0) begin
               fail("tx_unexpected", $sformatf("byte %0h transmitted", DSEND_O));
            end else begin
               check("tx_byte", {56'h0, DSEND_O}, {56'h0, exp_tx.pop_front()});
            end
            if (pending_tx > 0) pending_tx--;
         end
         if (REG_REQ_O) begin
            if (!req_active) begin
               req_active = 1'b1;
               ack_cnt    = 0;
               cur_req    = {REG_WE_O, REG_ADDR_O, REG_WDATA_O};
               if (exp_req.size() == 0) begin
                  fail("req_unexpected", $sformatf("addr %0h we %0b", REG_ADDR_O, REG_WE_O));
               end else begin
                  e = exp_req.pop_front();
                  check("req_we", {63'h0, REG_WE_O}, {63'h0, e.we});
                  check("req_addr", {56'h0, REG_ADDR_O}, {56'h0, e.addr});
                  if (e.we) check("req_wdata", {32'h0, REG_WDATA_O}, {32'h0, e.wdata});
               end
            end else begin
               check("req_stable", {23'h0, REG_WE_O, REG_ADDR_O, REG_WDATA_O}, {23'h0, cur_req});
            end
            if (ack_en) begin
               if (ack_cnt >= ack_delay) begin
                  REG_ACK_I   = 1'b1;
                  REG_RDATA_I = periph[REG_ADDR_O];
                  if (REG_WE_O) periph[REG_ADDR_O] = REG_WDATA_O;
                  pending_tx += REG_WE_O ? 1 : 4;
                  req_active  = 1'b0;
                  expect_drop = 1'b1;
               end else begin
                  ack_cnt++;
               end
            end
         end else if (stray_ack) begin
            REG_ACK_I   = 1'b1;
            REG_RDATA_I = 32'hBAD0BAD0;
            stray_ack   = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      if (re_s) void'(rx_q.pop_front());
      cyc++;
      case (tx_mode)
         0:       TX_READY_I = 1'b1;
         1:       TX_READY_I = cyc[0];
         default: TX_READY_I = (cyc % 3 == 0);
      endcase
      refresh_rx();
   endtask

   // Frame-level model: walks frm and derives requests and reply bytes.
   task automatic model(input bit resp);
      int i;
      logic [7:0]  cmd;
      logic [7:0]  addr;
      logic [31:0] d;
      i = 0;
      while (i < frm.size()) begin
         if (frm[i] != 8'h5A) begin
            i++;
            continue;
         end
         if (i + 1 >= frm.size()) break;
         cmd = frm[i+1];
         if (cmd != 8'h01 && cmd != 8'h02) begin
            exp_tx.push_back(8'hEE);
            i += 2;
            continue;
         end
         if (i + 2 >= frm.size()) break;
         addr = frm[i+2];
         if (cmd == 8'h01) begin
            exp_req.push_back({1'b0, addr, 32'h0});
            if (resp) for (int k = 0; k < 4; k++) exp_tx.push_back(8'(mdl_mem[addr] >> (8*k)));
            i += 3;
         end else begin
            if (i + 6 >= frm.size()) break;
            d = {frm[i+6], frm[i+5], frm[i+4], frm[i+3]};
            exp_req.push_back({1'b1, addr, d});
            if (resp) begin
               mdl_mem[addr] = d;
               exp_tx.push_back(8'hA5);
            end
            i += 7;
         end
      end
   endtask

   task automatic send();
      foreach (frm[k]) rx_q.push_back(frm[k]);
      refresh_rx();
   endtask

   task automatic wait_rx(input string name);
      int n;
      n = 0;
      while (rx_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      if (rx_q.size() != 0) fail(name, "receive FIFO not drained in 200 cycles");
   endtask

   task automatic wait_done(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (rx_q.size() == 0 && exp_tx.size() == 0 && exp_req.size() == 0 &&
             !req_active && pending_tx == 0) begin
            done = 1'b1;
            break;
         end
         tick();
      end
      if (!done) begin
         fail(name, $sformatf("not complete: %0d tx and %0d requests outstanding",
                              exp_tx.size(), exp_req.size()));
         exp_tx.delete();
         exp_req.delete();
         pending_tx = 0;
      end
      repeat (5) tick();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_re"},    {63'h0, RE_O},       64'h0);
      check({tag, "_we"},    {63'h0, WE_O},       64'h0);
      check({tag, "_dsend"}, {56'h0, DSEND_O},    64'h0);
      check({tag, "_req"},   {63'h0, REG_REQ_O},  64'h0);
      check({tag, "_rwe"},   {63'h0, REG_WE_O},   64'h0);
      check({tag, "_addr"},  {56'h0, REG_ADDR_O}, 64'h0);
      check({tag, "_wdata"}, {32'h0, REG_WDATA_O}, 64'h0);
   endtask

   task automatic do_reset();
      RST_I = 1'b1;
      rx_q.delete();
      refresh_rx();
      tick();
      RST_I       = 1'b0;
      req_active  = 1'b0;
      expect_drop = 1'b0;
      pending_tx  = 0;
      REG_ACK_I   = 1'b0;
      exp_tx.delete();
      exp_req.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         periph[i]  = (32'(i) * 32'h01010101) ^ 32'hA5C30F96;
         mdl_mem[i] = periph[i];
      end
      periph[8'h20]  = 32'hDEADBEEF;
      mdl_mem[8'h20] = 32'hDEADBEEF;

      // Reset state
      RST_I = 1'b1;
      tick();
      tick();
      RST_I = 1'b0;
      check_zero("reset");

      // Write frame, ack in the first request cycle
      ack_delay = 0;
      frm = {8'h5A, 8'h02, 8'h10, 8'h44, 8'h33, 8'h22, 8'h11};
      model(1'b1);
      check("pin_wr_req", {23'h0, exp_req[0]}, {23'h0, 1'b1, 8'h10, 32'h11223344});
      check("pin_wr_tx", {56'h0, exp_tx[0]}, 64'hA5);
      check("pin_wr_ntx", 64'(exp_tx.size()), 64'd1);
      send();
      wait_done("write");

      // Read frame with the transmit side toggling ready
      tx_mode   = 1;
      ack_delay = 1;
      frm = {8'h5A, 8'h01, 8'h20};
      model(1'b1);
      check("pin_rd_tx", {32'h0, exp_tx[3], exp_tx[2], exp_tx[1], exp_tx[0]}, 64'hDEADBEEF);
      check("pin_rd_req", {23'h0, exp_req[0].we, exp_req[0].addr}, {23'h0, 1'b0, 8'h20});
      send();
      wait_done("read");

      // Garbage then bad command; stray ack while idle must be ignored
      tx_mode = 2;
      frm = {8'h00, 8'hFF, 8'h5A, 8'h07};
      model(1'b1);
      check("pin_err_tx", {56'h0, exp_tx[0]}, 64'hEE);
      check("pin_err_nreq", 64'(exp_req.size()), 64'd0);
      send();
      wait_done("badcmd");
      stray_ack = 1'b1;
      tick();
      tick();
      frm = {8'h5A, 8'h01, 8'h33};
      model(1'b1);
      send();
      wait_done("after_err");

      // Gap of 15 cycles inside a frame: still accepted
      tx_mode = 0;
      frm = {8'h5A, 8'h02, 8'h11, 8'h01, 8'h02, 8'h03, 8'h04};
      model(1'b1);
      for (int k = 0; k < 3; k++) rx_q.push_back(frm[k]);
      wait_rx("gap15_rx");
      repeat (15) tick();
      for (int k = 3; k < 7; k++) rx_q.push_back(frm[k]);
      wait_done("gap15");

      // Gap of 16 cycles: frame dropped silently, next frame normal
      frm = {8'h5A, 8'h02, 8'h10};
      send();
      wait_rx("tmo_rx");
      repeat (16) tick();
      frm = {8'h5A, 8'h01, 8'h10};
      model(1'b1);
      check("pin_tmo_rd", {32'h0, exp_tx[3], exp_tx[2], exp_tx[1], exp_tx[0]}, 64'h11223344);
      send();
      wait_done("timeout");

      // Reset in DATA
      frm = {8'h5A, 8'h02, 8'h10, 8'h44, 8'h33};
      send();
      wait_rx("rst_data_rx");
      tick();
      do_reset();
      check_zero("rst_data");
      repeat (10) tick();

      // Reset in REQ (never acked)
      ack_en = 1'b0;
      frm = {8'h5A, 8'h02, 8'h30, 8'h01, 8'h02, 8'h03, 8'h04};
      model(1'b0);
      send();
      for (int i = 0; i < 100 && !req_active; i++) tick();
      check("rst_req_seen", {63'h0, req_active}, 64'h1);
      repeat (3) tick();
      do_reset();
      check_zero("rst_req");
      ack_en = 1'b1;
      repeat (10) tick();
      frm = {8'h5A, 8'h02, 8'h30, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h5A, 8'h01, 8'h30};
      model(1'b1);
      check("pin_rst_rd", {32'h0, exp_tx[4], exp_tx[3], exp_tx[2], exp_tx[1]}, 64'hAABBCCDD);
      send();
      wait_done("after_reset");

      // Two read frames queued back to back
      tx_mode   = 1;
      ack_delay = 2;
      frm = {8'h5A, 8'h01, 8'h20, 8'h5A, 8'h01, 8'h44};
      model(1'b1);
      check("pin_b2b_ntx", 64'(exp_tx.size()), 64'd8);
      send();
      wait_done("b2b");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
